patp_sequencer: RTL
===================

PATP_SEQUENCER -- requirements
Module: patp_sequencer

Interface
REQ-001 Parameters: none; all widths fixed.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 run  in  1  1 = execute instructions; sampled only in IDLE and at each instruction boundary.
REQ-005 ir_op  in  3  opcode field from IR, valid from the cycle after clk_ir.
REQ-006 acc_zero  in  1  1 when accumulator == 8'd0.
REQ-007 mem_ready  in  1  memory completes the current mem_rd/mem_wr this cycle.
REQ-008 Outputs, 1 bit each unless stated:
- clk_mar: load MAR.
- mar_src: MAR source, 0 = PC, 1 = IR address.
- clk_ir: load IR.
- clk_pc: PC increment.
- pc_load: PC <= IR address.
- mem_rd, mem_wr: memory read and write requests.
- clk_alureg: load ALU result register.
- clk_acc: load ACC from ALU register.
- alu_op (2 bits): ALU function.
- halted.
- state (4 bits): debug encoding.
- icount (8 bits): retired-instruction count.

Function
REQ-009 States: IDLE=0, FETCH_A=1, FETCH_B=2, DECODE=3, EXEC_B=4, EXEC_C=5, HALTED=6; all other codes go to IDLE on the next edge.
REQ-010 Opcode map:
- 000 LOAD, 001 STORE, 010 ADD, 011 SUB.
- 100 JMP, 101 JEZ, 110 NOP, 111 HALT.
REQ-011 alu_op: LOAD=00 (pass B), ADD=01, SUB=10; 00 in all other cases.
REQ-012 IDLE: all strobes 0. Next state is FETCH_A if run=1, else IDLE.
REQ-013 FETCH_A:
- Asserts clk_mar with mar_src=0.
- Next state FETCH_B.
REQ-014 FETCH_B:
- Asserts mem_rd.
- If mem_ready=1: asserts clk_ir and clk_pc in the same cycle; next state DECODE.
- Else: holds in FETCH_B with no strobes except mem_rd, with no limit on wait states.
REQ-015 DECODE:
- Registers ir_op into an internal op register, used by all later states of the instruction.
- LOAD/STORE/ADD/SUB: asserts clk_mar with mar_src=1; next state EXEC_B.
- JMP: asserts pc_load; instruction retires.
- JEZ: pc_load = acc_zero; instruction retires.
- NOP: instruction retires.
- HALT: next state HALTED; icount increments.
REQ-016 EXEC_B:
- STORE: asserts mem_wr. On mem_ready=1 the instruction retires; otherwise holds.
- LOAD/ADD/SUB: asserts mem_rd, with alu_op driven from the op register. On mem_ready=1 asserts clk_alureg; next state EXEC_C. Otherwise holds.
REQ-017 EXEC_C:
- Asserts clk_acc, with alu_op still driven.
- Instruction retires.
REQ-018 Retire means icount <= icount+1 (mod 256, 8'hFF wraps to 8'h00). Next state is FETCH_A if run=1, else IDLE.
REQ-019 HALTED:
- halted=1, all strobes 0.
- Exits only via reset; run is ignored.
REQ-020 Strobes are combinational decodes of state, the op register, mem_ready and acc_zero. clk_ir, clk_pc and clk_alureg are high only in a cycle where mem_ready=1.
REQ-021 mem_rd and mem_wr are never high together. clk_mar and pc_load are never high together.
REQ-022 Zero-wait latencies in cycles, FETCH_A to retire inclusive:
- LOAD/ADD/SUB: 5.
- STORE: 4.
- JMP/JEZ/NOP: 3.
- Each mem_ready=0 cycle adds 1.
REQ-023 run=0 mid-instruction does not abort; the current instruction completes, then the block goes to IDLE.

Reset
REQ-024 rst_n=0 at a clock edge forces:
- state=IDLE, op register=000, icount=8'h00, halted=0.
- All strobes 0 in the following cycle, whatever the current state and any outstanding mem handshake.
REQ-025 Reset has priority over all transitions. A memory access in progress is abandoned; no retire and no icount increment.

Verification
REQ-026 LOAD, zero-wait, run=1 from reset:
- States 1,2,3,4,5 in consecutive cycles.
- clk_alureg in the state-4 cycle, clk_acc in the state-5 cycle, alu_op=00.
- icount 0->1; next state 1.
REQ-027 ADD with mem_ready low for 3 cycles in EXEC_B:
- mem_rd held for 4 cycles.
- clk_alureg exactly once, in the cycle mem_ready=1, alu_op=01.
- Total 8 cycles.
REQ-028 JEZ:
- acc_zero=1: pc_load=1 in DECODE.
- acc_zero=0: pc_load=0.
- Both cases: 3 cycles, no memory request after fetch.
REQ-029 Sequence STORE, HALT:
- mem_wr exactly one cycle with mem_ready=1; never with mem_rd.
- Then state=6, halted=1, icount=2.
- run toggles keep state 6; rst_n=0 for 1 cycle returns to IDLE with icount=0.
REQ-030 run dropped to 0 during FETCH_B of a SUB: SUB completes (alu_op=10 with clk_acc), then IDLE and stays there. icount preloaded to 8'hFF by 255 NOPs wraps to 8'h00 on the next retire.
REQ-031 rst_n=0 asserted in EXEC_B while mem_rd is waiting: next cycle state=0, mem_rd=0, icount unchanged from its reset value 0.

Source files
------------

// File: rtl/patp_sequencer.sv
// Control sequencer for a simple accumulator CPU: fetch/decode/execute FSM
// driving MAR/IR/PC/ALU/ACC load strobes and memory handshakes.
module patp_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run_i,
  input  logic [2:0] ir_op_i,
  input  logic       acc_zero_i,
  input  logic       mem_ready_i,
  output logic       clk_mar_o,
  output logic       mar_src_o,
  output logic       clk_ir_o,
  output logic       clk_pc_o,
  output logic       pc_load_o,
  output logic       mem_rd_o,
  output logic       mem_wr_o,
  output logic       clk_alureg_o,
  output logic       clk_acc_o,
  output logic [1:0] alu_op_o,
  output logic       halted_o,
  output logic [3:0] state_o,
  output logic [7:0] icount_o
);

  localparam int unsigned OP_W = 3;
  localparam int unsigned IC_W = 8;

  localparam logic [OP_W-1:0] OP_LOAD  = 3'b000;
  localparam logic [OP_W-1:0] OP_STORE = 3'b001;
  localparam logic [OP_W-1:0] OP_ADD   = 3'b010;
  localparam logic [OP_W-1:0] OP_SUB   = 3'b011;
  localparam logic [OP_W-1:0] OP_JMP   = 3'b100;
  localparam logic [OP_W-1:0] OP_JEZ   = 3'b101;
  localparam logic [OP_W-1:0] OP_NOP   = 3'b110;
  localparam logic [OP_W-1:0] OP_HALT  = 3'b111;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_FETCH_A = 4'd1,
    ST_FETCH_B = 4'd2,
    ST_DECODE  = 4'd3,
    ST_EXEC_B  = 4'd4,
    ST_EXEC_C  = 4'd5,
    ST_HALTED  = 4'd6
  } state_e;

  state_e            state_q, state_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [IC_W-1:0]   icount_q, icount_d;
  logic              halted_q;
  logic              retire;

  function automatic logic [1:0] alu_dec(input logic [OP_W-1:0] op);
    case (op)
      OP_ADD:  alu_dec = 2'b01;
      OP_SUB:  alu_dec = 2'b10;
      default: alu_dec = 2'b00;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_LOAD;
      icount_q <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      icount_q <= icount_d;
      halted_q <= (state_d == ST_HALTED);
    end
  end

  // Next state and strobe decode; retire is folded in after the case.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    icount_d     = icount_q;
    retire       = 1'b0;
    clk_mar_o    = 1'b0;
    mar_src_o    = 1'b0;
    clk_ir_o     = 1'b0;
    clk_pc_o     = 1'b0;
    pc_load_o    = 1'b0;
    mem_rd_o     = 1'b0;
    mem_wr_o     = 1'b0;
    clk_alureg_o = 1'b0;
    clk_acc_o    = 1'b0;
    alu_op_o     = 2'b00;

    case (state_q)
      ST_IDLE: begin
        if (run_i) state_d = ST_FETCH_A;
      end
      ST_FETCH_A: begin
        clk_mar_o = 1'b1;
        state_d   = ST_FETCH_B;
      end
      ST_FETCH_B: begin
        mem_rd_o = 1'b1;
        if (mem_ready_i) begin
          clk_ir_o = 1'b1;
          clk_pc_o = 1'b1;
          state_d  = ST_DECODE;
        end
      end
      ST_DECODE: begin
        op_d = ir_op_i;
        case (ir_op_i)
          OP_LOAD, OP_STORE, OP_ADD, OP_SUB: begin
            clk_mar_o = 1'b1;
            mar_src_o = 1'b1;
            state_d   = ST_EXEC_B;
          end
          OP_JMP: begin
            pc_load_o = 1'b1;
            retire    = 1'b1;
          end
          OP_JEZ: begin
            pc_load_o = acc_zero_i;
            retire    = 1'b1;
          end
          OP_NOP:  retire = 1'b1;
          OP_HALT: begin
            state_d  = ST_HALTED;
            icount_d = icount_q + IC_W'(1);
          end
          default: state_d = ST_IDLE;
        endcase
      end
      ST_EXEC_B: begin
        if (op_q == OP_STORE) begin
          mem_wr_o = 1'b1;
          if (mem_ready_i) retire = 1'b1;
        end else begin
          mem_rd_o = 1'b1;
          alu_op_o = alu_dec(op_q);
          if (mem_ready_i) begin
            clk_alureg_o = 1'b1;
            state_d      = ST_EXEC_C;
          end
        end
      end
      ST_EXEC_C: begin
        clk_acc_o = 1'b1;
        alu_op_o  = alu_dec(op_q);
        retire    = 1'b1;
      end
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_IDLE;
    endcase

    // Instruction boundary: count it and resample run.
    if (retire) begin
      icount_d = icount_q + IC_W'(1);
      state_d  = run_i ? ST_FETCH_A : ST_IDLE;
    end
  end

  assign halted_o = halted_q;
  assign state_o  = 4'(state_q);
  assign icount_o = icount_q;

endmodule
